cpu_fetch_sequencer: RTL
========================

// Module: cpu_fetch_sequencer
// PURPOSE
//  Sequences the 16-bit CPU datapath through fetch / execute / settle / next-PC for every instruction.
//  Owns the PC and the instruction register; issues a one-cycle execute strobe to the datapath.
//  Resolves jump conditions from the datapath flags, handles halt, and provides run/single-step control.
// PARAMETERS
//  PC_WIDTH     4   program-memory address width (16 x 32-bit words)
//  DELAY_CYCLES 4   settle cycles after execute before next-PC; 0 = no settle state
//  CNT_WIDTH    16  width of retired-instruction counter
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  sys_rst     in   1          synchronous, active-high reset
//  run         in   1          1 = free-run; 0 = pause at next instruction boundary
//  step        in   1          one-cycle pulse; in IDLE with run=0 executes exactly one instruction
//  inst_data   in   32         program-memory read data for address pc (combinational read)
//  flags       in   4          {sign, zero, overflow, carry} from datapath
//  pc          out  PC_WIDTH   program counter / program-memory address
//  inst_reg    out  32         latched current instruction to datapath decode
//  exec_en     out  1          high exactly one cycle per instruction: datapath executes + updates flags
//  busy        out  1          high in any state except IDLE and HALT
//  halted      out  1          high in HALT
//  retired     out  CNT_WIDTH  instructions completed since reset, saturates at all-ones
// BEHAVIOUR
//  Reset (sys_rst=1 at edge): state=IDLE, pc=0, inst_reg=0, exec_en=0, busy=0, halted=0, retired=0,
//   settle counter=0. Reset overrides every state, including mid-instruction and HALT.
//  States: IDLE, FETCH, EXEC, SETTLE, NEXT, HALT.
//  IDLE:   run=1 or step=1 -> FETCH; else stay. step latched as single-step for this instruction.
//  FETCH:  inst_reg <= inst_data -> EXEC.
//  EXEC:   exec_en=1 (decoded from state, this cycle only) -> SETTLE (or NEXT if DELAY_CYCLES=0).
//  SETTLE: counter counts 0..DELAY_CYCLES-1; on last count -> NEXT; counter cleared on exit.
//  NEXT:   opcode=inst_reg[31:27], immed=inst_reg[15:0].
//   - opcode 5'b11011 (halt): pc unchanged -> HALT; retired increments.
//   - else retired increments; pc <= taken ? immed[PC_WIDTH-1:0] : pc+1 (wraps 2^PC_WIDTH-1 -> 0).
//   - next state FETCH if run=1 and not single-step; otherwise IDLE.
//  HALT:   halted=1, pc frozen, run/step ignored; exit only by sys_rst.
//  Jump taken (evaluated in NEXT on flags as sampled that cycle):
//   10010 always; 10011 carry; 10100 !carry; 10101 sign; 10110 !sign;
//   10111 zero; 11000 !zero; 11001 overflow; 11010 !overflow; all other opcodes not taken.
//  Immediate bits above PC_WIDTH ignored (no fault). Unknown opcodes execute as normal, pc+1.
//  Latency: 3 + DELAY_CYCLES cycles per instruction (7 at defaults), FETCH to FETCH.
//  run dropped mid-instruction: current instruction completes through NEXT, then IDLE; pc holds next address.
//  step while busy ignored. run and step together in IDLE: run wins (free-run).
//  retired at all-ones stays all-ones.
//  Illegal state encoding -> IDLE next cycle.
// TESTING
//  1 reset, run=1, prog {mov,add,halt}, DELAY=4 -> exec_en at cycles 2,9,16; HALT; pc=2; retired=3.
//  2 inst@0 = jump immed=5 -> pc 0->5 after NEXT; inst@5 = jzero immed=9, flags.zero=0 -> pc=6; zero=1 -> pc=9.
//  3 pc=15, non-jump instruction -> pc wraps to 0; jump immed=16'h0013 -> pc=3.
//  4 run=0, step pulse in IDLE -> exactly one exec_en, returns IDLE with pc+1, retired+1; step while busy ignored.
//  5 sys_rst asserted in SETTLE and in HALT -> next cycle IDLE, pc=0, inst_reg=0, halted=0, retired=0.
//  6 DELAY_CYCLES=0 -> FETCH-to-FETCH 3 cycles; all nine jump opcodes checked against each flag value.

Source files
------------

// File: rtl/cpu_fetch_sequencer.sv
// Fetch/execute/settle/next-PC sequencer for the 16-bit CPU datapath.
// Owns the PC and instruction register, strobes the datapath once per instruction.
module cpu_fetch_sequencer #(
  parameter int PC_WIDTH     = 4,
  parameter int DELAY_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 run,
  input  logic                 step,
  input  logic [31:0]          inst_data,
  input  logic [3:0]           flags,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [31:0]          inst_reg,
  output logic                 exec_en,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_SETTLE = 3'd3,
    S_NEXT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = (DELAY_CYCLES > 0) ? CW'(DELAY_CYCLES - 1) : '0;

  state_t        state, state_nxt;
  logic [CW-1:0] settle_cnt;
  logic          single_step;
  logic [4:0]    opcode;
  logic          taken;
  logic          last_settle;

  assign opcode      = inst_reg[31:27];
  assign last_settle = (settle_cnt == LAST_CNT);
  assign exec_en     = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign busy        = (state != S_IDLE) && (state != S_HALT);

  // flags = {sign, zero, overflow, carry}
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    taken = 1'b0;
    case (opcode)
      5'b10010: taken = 1'b1;
      5'b10011: taken = flags[0];
      5'b10100: taken = ~flags[0];
      5'b10101: taken = flags[3];
      5'b10110: taken = ~flags[3];
      5'b10111: taken = flags[2];
      5'b11000: taken = ~flags[2];
      5'b11001: taken = flags[1];
      5'b11010: taken = ~flags[1];
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run || step) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (DELAY_CYCLES == 0) ? S_NEXT : S_SETTLE;
      S_SETTLE: if (last_settle) state_nxt = S_NEXT;
      S_NEXT: begin
        if (opcode == OP_HALT)         state_nxt = S_HALT;
        else if (run && !single_step)  state_nxt = S_FETCH;
        else                           state_nxt = S_IDLE;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pc          <= '0;
      inst_reg    <= '0;
      settle_cnt  <= '0;
      single_step <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        // run wins over step when both are present in IDLE
        S_IDLE:   if (run || step) single_step <= ~run;
        S_FETCH:  inst_reg <= inst_data;
        S_SETTLE: settle_cnt <= last_settle ? '0 : settle_cnt + CW'(1);
        S_NEXT: begin
          if (retired != '1) retired <= retired + CNT_WIDTH'(1);
          if (opcode != OP_HALT)
            pc <= taken ? inst_reg[PC_WIDTH-1:0] : pc + PC_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
